// File: rtl/fifo_sync_level.sv
// AXI-Stream FIFO with tid/tlast sideband, fill level and almost-full/empty flags; optional store-and-forward via FIFO_SYNC_PACKET_EN.
// Latency: a word accepted at edge k appears on m_axis after edge k+1 (empty FIFO, free output register).
// Backpressure: s_axis_tready drops on a full memory and returns one cycle after a pop; m_axis holds steady while stalled.
module fifo_sync_level #(
   parameter int DW        = 24,
   parameter int TIDW      = 8,
   parameter int N         = 16,
   parameter int AF_THRESH = 12,
   parameter int AE_THRESH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DW-1:0]           s_axis_tdata,
   input  logic [TIDW-1:0]         s_axis_tid,
   input  logic                    s_axis_tlast,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [DW-1:0]           m_axis_tdata,
   output logic [TIDW-1:0]         m_axis_tid,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [$clog2(N+1):0]    level,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic                    overflow
);

   localparam int AW = $clog2(N);
   localparam int LW = $clog2(N+1) + 1;
   localparam logic [AW:0]   CTR_ONE = (AW+1)'(1);
   localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
   localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);
   localparam logic [LW-1:0] FULL_L  = LW'(N + 1);

   generate
      if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_depth
         $error("fifo_sync_level: N must be a power of 2 and >= 2");
      end
   endgenerate

   typedef struct packed {
      logic [DW-1:0]   tdata;
      logic [TIDW-1:0] tid;
      logic            tlast;
   } word_t;

   word_t       mem [N];
   word_t       rd_word, wr_word;
   word_t       out_q, out_d;
   logic        tvalid_q, tvalid_d;
   logic        ovf_q, ovf_d;
   logic [AW:0] wr_ctr_q, wr_ctr_d, rd_ctr_q, rd_ctr_d;
   logic [AW:0] fill;
   logic        empty, full, wr_en, pop, rel_ok;

   assign empty = (rd_ctr_q == wr_ctr_q);
   assign full  = (rd_ctr_q[AW] != wr_ctr_q[AW]) && (rd_ctr_q[AW-1:0] == wr_ctr_q[AW-1:0]);

   assign s_axis_tready = !full && !rst;
   assign wr_en         = s_axis_tvalid && s_axis_tready;
   assign wr_word       = '{tdata: s_axis_tdata, tid: s_axis_tid, tlast: s_axis_tlast};
   assign rd_word       = mem[rd_ctr_q[AW-1:0]];
   assign pop           = !empty && (!tvalid_q || m_axis_tready) && rel_ok;

`ifdef FIFO_SYNC_PACKET_EN
   localparam int PW = $clog2(N+1);
   localparam logic [PW-1:0] PKT_ONE = PW'(1);
   logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic          wr_last, pop_last;

   always_comb begin
      wr_last   = wr_en && s_axis_tlast;
      pop_last  = pop && rd_word.tlast;
      pkt_cnt_d = pkt_cnt_q;
      if (wr_last && !pop_last)
         pkt_cnt_d = pkt_cnt_q + PKT_ONE;
      else if (!wr_last && pop_last)
         pkt_cnt_d = pkt_cnt_q - PKT_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pkt_cnt_q <= '0;
      else     pkt_cnt_q <= pkt_cnt_d;
   end

   // A full memory releases anyway so a packet larger than N cannot wedge the writer.
   assign rel_ok = (pkt_cnt_q != '0) || full;
`else
   assign rel_ok = 1'b1;
`endif

   always_comb begin
      wr_ctr_d = wr_en ? wr_ctr_q + CTR_ONE : wr_ctr_q;
      rd_ctr_d = pop   ? rd_ctr_q + CTR_ONE : rd_ctr_q;
      out_d    = out_q;
      tvalid_d = tvalid_q;
      if (pop) begin
         out_d    = rd_word;
         tvalid_d = 1'b1;
      end else if (m_axis_tready) begin
         tvalid_d = 1'b0;
      end
      ovf_d = ovf_q || (s_axis_tvalid && !s_axis_tready && (level == FULL_L));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ctr_q <= '0;
         rd_ctr_q <= '0;
         out_q    <= '0;
         tvalid_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ctr_q <= wr_ctr_d;
         rd_ctr_q <= rd_ctr_d;
         out_q    <= out_d;
         tvalid_q <= tvalid_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ctr_q[AW-1:0]] <= wr_word;
   end

   assign fill          = wr_ctr_q - rd_ctr_q;
   assign level         = LW'(fill) + LW'(tvalid_q);
   assign almost_full   = (level >= AF_L);
   assign almost_empty  = (level <= AE_L);
   assign overflow      = ovf_q;
   assign m_axis_tdata  = out_q.tdata;
   assign m_axis_tid    = out_q.tid;
   assign m_axis_tlast  = out_q.tlast;
   assign m_axis_tvalid = tvalid_q;

endmodule
